// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver, LSB first, oversampled by an external baud_tick
//   strobe running at OSR times the bit rate. Each bit is sampled once,
//   in the middle of the bit, using a baud_tick counter.
//
// Parameters
//   OSR          baud_tick pulses per UART bit (even, >= 4)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   baud_tick    one-clk strobe at OSR x bit rate
//   rx           asynchronous serial input, idles high
//   o_rx_data    last received byte, held until the next frame completes
//   o_rx_done    one-clk pulse when a frame completes
//   o_rx_busy    high from start-edge detection until return to idle
//   o_frame_err  stop-bit status of the last frame (1 = stop bit was 0)
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int unsigned OSR = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_tick,
   input  logic       rx,
   output logic [7:0] o_rx_data,
   output logic       o_rx_done,
   output logic       o_rx_busy,
   output logic       o_frame_err
);

   localparam int unsigned BW = (OSR > 1) ? $clog2(OSR) : 1;
   localparam logic [BW-1:0] B_HALF = BW'(OSR / 2 - 1);
   localparam logic [BW-1:0] B_LAST = BW'(OSR - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state, state_next;
   logic [BW-1:0]   b_cnt, b_cnt_next;
   logic [2:0]      bit_cnt, bit_cnt_next;
   logic [7:0]      shift, shift_next;
   logic [7:0]      data_next;
   logic            done_next;
   logic            busy_next;
   logic            ferr_next;
   logic            rx_meta, rx_s;

   // Two-flop synchronizer; resets to the idle line level so a reset
   // release never looks like a start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         b_cnt       <= '0;
         bit_cnt     <= '0;
         shift       <= '0;
         o_rx_data   <= '0;
         o_rx_done   <= 1'b0;
         o_rx_busy   <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         state       <= state_next;
         b_cnt       <= b_cnt_next;
         bit_cnt     <= bit_cnt_next;
         shift       <= shift_next;
         o_rx_data   <= data_next;
         o_rx_done   <= done_next;
         o_rx_busy   <= busy_next;
         o_frame_err <= ferr_next;
      end
   end

   always_comb begin
      state_next   = state;
      b_cnt_next   = b_cnt;
      bit_cnt_next = bit_cnt;
      shift_next   = shift;
      data_next    = o_rx_data;
      ferr_next    = o_frame_err;
      done_next    = 1'b0;

      unique case (state)
         IDLE: begin
            b_cnt_next   = '0;
            bit_cnt_next = '0;
            // Start edge is detected on any clk, not just on a tick.
            if (!rx_s) begin
               state_next = START;
            end
         end

         START: begin
            if (baud_tick) begin
               if (b_cnt == B_HALF) begin
                  // Mid start bit: a high line here means a glitch.
                  b_cnt_next   = '0;
                  bit_cnt_next = '0;
                  state_next   = rx_s ? IDLE : DATA;
               end else begin
                  b_cnt_next = b_cnt + 1'b1;
               end
            end
         end

         DATA: begin
            if (baud_tick) begin
               if (b_cnt == B_LAST) begin
                  b_cnt_next          = '0;
                  shift_next[bit_cnt] = rx_s;
                  if (bit_cnt == 3'd7) begin
                     state_next = STOP;
                  end else begin
                     bit_cnt_next = bit_cnt + 3'd1;
                  end
               end else begin
                  b_cnt_next = b_cnt + 1'b1;
               end
            end
         end

         STOP: begin
            if (baud_tick) begin
               if (b_cnt == B_LAST) begin
                  // Data is published even on a bad stop bit;
                  // o_frame_err qualifies it.
                  b_cnt_next = '0;
                  data_next  = shift;
                  ferr_next  = ~rx_s;
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  b_cnt_next = b_cnt + 1'b1;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

   localparam int unsigned OSR = 16;

   logic       clk;
   logic       rst;
   logic       baud_tick;
   logic       rx;
   logic [7:0] o_rx_data;
   logic       o_rx_done;
   logic       o_rx_busy;
   logic       o_frame_err;

   int unsigned tests_run = 0;
   int unsigned tests_failed = 0;

   logic       tick_en;
   int unsigned div = 0;

   // Expected {frame_err, data} for every o_rx_done the DUT should emit.
   logic [8:0] exp_q[$];
   logic [7:0] last_data;

   uart_rx #(.OSR(OSR)) dut (
      .clk         (clk),
      .rst         (rst),
      .baud_tick   (baud_tick),
      .rx          (rx),
      .o_rx_data   (o_rx_data),
      .o_rx_done   (o_rx_done),
      .o_rx_busy   (o_rx_busy),
      .o_frame_err (o_frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // baud_tick every 4 clks while enabled.
   initial begin
      baud_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         div = div + 1;
         baud_tick = tick_en && (div % 4 == 0);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (o_rx_done === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("FAIL unexpected_done: got data 0x%0h ferr %0b, expected no frame at %0t",
                        o_rx_data, o_frame_err, $time);
            end else begin
               e = exp_q.pop_front();
               chk("rx_data", {24'd0, o_rx_data}, {24'd0, e[7:0]});
               chk("frame_err", {31'd0, o_frame_err}, {31'd0, e[8]});
            end
         end
      end
   end

   task automatic wait_tick();
      do @(posedge clk); while (baud_tick !== 1'b1);
      #1;
   endtask

   task automatic hold_bit(input logic b, input int unsigned ticks, input bit gap);
      rx = b;
      if (gap) begin
         repeat (ticks / 2) wait_tick();
         tick_en = 1'b0;
         repeat (100) begin
            @(negedge clk);
            chk("gap_busy", {31'd0, o_rx_busy}, 32'd1);
         end
         @(posedge clk);
         tick_en = 1'b1;
         repeat (ticks - ticks / 2) wait_tick();
      end else begin
         repeat (ticks) wait_tick();
      end
   endtask

   // stop_ticks lets a low stop bit end early so the FSM sees a false start
   // afterwards instead of a phantom frame.
   task automatic send_frame(input logic [7:0] d, input logic stop_val,
                             input int unsigned stop_ticks, input int gap_bit);
      hold_bit(1'b0, OSR, 1'b0);
      for (int i = 0; i < 8; i++) begin
         hold_bit(d[i], OSR, (i == gap_bit));
      end
      hold_bit(stop_val, stop_ticks, 1'b0);
      rx = 1'b1;
   endtask

   task automatic expect_frame(input logic [7:0] d, input logic ferr);
      exp_q.push_back({ferr, d});
      last_data = d;
   endtask

   initial begin
      int unsigned guard;
      rst = 1'b0;
      rx = 1'b1;
      tick_en = 1'b1;
      last_data = 8'h00;
      repeat (5) @(posedge clk);
      #2;
      chk("reset_data", {24'd0, o_rx_data}, 32'h00);
      chk("reset_done", {31'd0, o_rx_done}, 32'd0);
      chk("reset_busy", {31'd0, o_rx_busy}, 32'd0);
      chk("reset_ferr", {31'd0, o_frame_err}, 32'd0);
      rst = 1'b1;
      repeat (2 * OSR) wait_tick();
      chk("idle_busy", {31'd0, o_rx_busy}, 32'd0);

      // Single frame
      expect_frame(8'h55, 1'b0);
      send_frame(8'h55, 1'b1, OSR, -1);
      repeat (4) wait_tick();
      chk("s1_busy_after", {31'd0, o_rx_busy}, 32'd0);

      // Back-to-back
      expect_frame(8'hA5, 1'b0);
      send_frame(8'hA5, 1'b1, OSR, -1);
      expect_frame(8'h3C, 1'b0);
      send_frame(8'h3C, 1'b1, OSR, -1);
      repeat (2 * OSR) wait_tick();

      // False start
      rx = 1'b0;
      repeat (3) wait_tick();
      chk("fs_busy_high", {31'd0, o_rx_busy}, 32'd1);
      rx = 1'b1;
      repeat (OSR) wait_tick();
      chk("fs_busy_low", {31'd0, o_rx_busy}, 32'd0);
      chk("fs_data_kept", {24'd0, o_rx_data}, {24'd0, last_data});

      // Framing error, then a clean frame clears it
      expect_frame(8'hFF, 1'b1);
      send_frame(8'hFF, 1'b0, OSR / 2 + 2, -1);
      repeat (2 * OSR) wait_tick();
      chk("fe_busy_low", {31'd0, o_rx_busy}, 32'd0);
      expect_frame(8'h55, 1'b0);
      send_frame(8'h55, 1'b1, OSR, -1);
      repeat (2 * OSR) wait_tick();

      // Reset mid-frame during data bit 4 of 0x81
      hold_bit(1'b0, OSR, 1'b0);
      for (int i = 0; i < 4; i++) hold_bit(i == 0, OSR, 1'b0);
      hold_bit(1'b0, OSR / 2, 1'b0);
      rst = 1'b0;
      #1;
      chk("mrst_data", {24'd0, o_rx_data}, 32'h00);
      chk("mrst_busy", {31'd0, o_rx_busy}, 32'd0);
      chk("mrst_done", {31'd0, o_rx_done}, 32'd0);
      chk("mrst_ferr", {31'd0, o_frame_err}, 32'd0);
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      last_data = 8'h00;
      repeat (2 * OSR) wait_tick();
      chk("mrst_idle", {31'd0, o_rx_busy}, 32'd0);
      expect_frame(8'h81, 1'b0);
      send_frame(8'h81, 1'b1, OSR, -1);
      repeat (2 * OSR) wait_tick();

      // Tick gating mid-DATA (during bit 2)
      expect_frame(8'hC3, 1'b0);
      send_frame(8'hC3, 1'b1, OSR, 2);
      repeat (2 * OSR) wait_tick();
      chk("final_busy", {31'd0, o_rx_busy}, 32'd0);

      guard = 0;
      while (exp_q.size() != 0 && guard < 1000) begin
         @(posedge clk);
         guard++;
      end
      while (exp_q.size() != 0) begin
         logic [8:0] e;
         e = exp_q.pop_front();
         tests_run++;
         tests_failed++;
         $display("FAIL missing_done: got no frame, expected data 0x%0h ferr %0b", e[7:0], e[8]);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OSR, default 16: baud_tick pulses per UART bit; legal values are even and at least 4.
REQ-002 Port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset is asynchronous and active-low; rst=0 forces the reset state immediately.
REQ-004 Port baud_tick, input, 1 bit: one-clk-wide pulse at OSR times the bit rate.
REQ-005 Port rx, input, 1 bit: asynchronous serial line; idles high; 8N1 framing, LSB first.
REQ-006 Port o_rx_data, output, 8 bits: last received byte; held until the next frame completes.
REQ-007 Port o_rx_done, output, 1 bit: one-clk pulse when a frame completes.
REQ-008 Port o_rx_busy, output, 1 bit: high from start-edge detection until return to IDLE.
REQ-009 Port o_frame_err, output, 1 bit: stop-bit status of the last frame; updated with each o_rx_done pulse.

Function
REQ-010 The block SHALL pass rx through a 2-flop synchronizer (reset value 1) and use only the synchronized value, rx_s.
REQ-011 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-012 All outputs SHALL be registered.
REQ-013 Counters:
- b_cnt: width clog2(OSR), counts baud_tick pulses.
- bit_cnt: 3 bits.
REQ-014 IDLE behaviour:
- b_cnt and bit_cnt are cleared.
- When rx_s=0 in any clk (tick not required), the FSM goes to START and o_rx_busy is set next clk.
REQ-015 START behaviour:
- Each baud_tick increments b_cnt.
- On the tick where b_cnt==OSR/2-1, rx_s is sampled (mid start bit).
- If rx_s=0, the FSM goes to DATA with b_cnt=0 and bit_cnt=0.
- If rx_s=1 (false start), the FSM returns to IDLE with no o_rx_done and no change to o_rx_data or o_frame_err.
REQ-016 DATA behaviour:
- On the tick where b_cnt==OSR-1, rx_s is written into shift bit [bit_cnt] and b_cnt is cleared.
- After bit_cnt==7 is sampled, the FSM goes to STOP.
- Otherwise bit_cnt increments.
REQ-017 STOP behaviour, on the tick where b_cnt==OSR-1:
- o_rx_data is loaded from the shift register.
- o_frame_err is set to the inverse of rx_s.
- o_rx_done pulses high for exactly one clk.
- The FSM goes to IDLE and o_rx_busy falls.
REQ-018 o_rx_data SHALL be updated even when a framing error occurs; o_frame_err qualifies it.
REQ-019 Because the stop bit is sampled mid-bit, a start edge arriving within half a bit after the stop sample SHALL be detected (back-to-back frames).
REQ-020 Outside the IDLE edge detect, the FSM and counters SHALL change only on clks where baud_tick=1.
REQ-021 Glitches on rx SHALL have no effect while in DATA or STOP except through the sampled bit value.
REQ-022 Latency: o_rx_done rises one clk after the clk carrying the stop-sample baud_tick.

Reset
REQ-023 On rst=0, the block SHALL reset as follows:
- State: IDLE.
- b_cnt and bit_cnt: 0.
- Shift register: 0.
- Synchronizer flops: 1.
- o_rx_data: 0x00; o_rx_done, o_rx_busy, o_frame_err: 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no o_rx_done.
REQ-025 After reset releases, the block SHALL wait for a new falling edge while in IDLE before starting a frame.

Verification
REQ-026 Scenario 1, single valid frame: OSR=16, rx carries 0x55 with a valid stop bit. Required: o_rx_done pulses once, o_rx_data=0x55, o_frame_err=0, o_rx_busy low after completion.
REQ-027 Scenario 2, back-to-back frames: 0xA5 then 0x3C with no idle gap. Required: two o_rx_done pulses, data 0xA5 then 0x3C, no frame lost.
REQ-028 Scenario 3, false start: rx low for 3 ticks, then high. Required: return to IDLE, o_rx_busy drops, no o_rx_done, o_rx_data unchanged.
REQ-029 Scenario 4, framing error: frame 0xFF with stop bit held 0. Required: o_rx_done pulses, o_rx_data=0xFF, o_frame_err=1; the next valid frame clears o_frame_err to 0.
REQ-030 Scenario 5, reset mid-frame: rst=0 during DATA bit 4 of 0x81. Required: outputs take reset values at once, no o_rx_done; a following 0x81 frame is received correctly.
REQ-031 Scenario 6, tick-gating check: baud_tick held 0 for 100 clks mid-DATA. Required: state, b_cnt and bit_cnt frozen; frame resumes and completes correctly when ticks resume.
